// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state encoding and default width for the sequential divider
package seq_divider_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int DIV_WIDTH_DEFAULT = 4;
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one restoring-division iteration producing the next remainder and quotient bit
module div_restore_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   r_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   r_o,
  output logic             q_o
);
  logic [WIDTH:0] shifted, t;
  logic unused_r_msb;
  assign unused_r_msb = r_i[WIDTH];
  assign shifted = {r_i[WIDTH-1:0], bit_i};
  assign t = shifted - {1'b0, d_i};
  // The partial remainder is always below D, so the sign of T decides the bit.
  assign q_o = ~t[WIDTH];
  assign r_o = q_o ? t : shifted;
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e state_q;
  logic [WIDTH:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, d_q;
  logic [CW-1:0] cnt_q;
  logic dbz_q, qbit_d;
  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .r_i(r_q),
    .bit_i(q_q[WIDTH-1]),
    .d_i(d_q),
    .r_o(r_d),
    .q_o(qbit_d)
  );
  // Q and R double as the result registers, so a zero divisor loads the result directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          d_q     <= divisor;
          cnt_q   <= '0;
          dbz_q   <= divisor == '0;
          q_q     <= divisor == '0 ? '1 : dividend;
          r_q     <= divisor == '0 ? {1'b0, dividend} : '0;
          state_q <= divisor == '0 ? DONE : RUN;
        end
        RUN: begin
          r_q   <= r_d;
          q_q   <= {q_q[WIDTH-2:0], qbit_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready    = state_q == IDLE;
  assign out_valid   = state_q == DONE;
  assign quotient    = q_q;
  assign remainder   = r_q[WIDTH-1:0];
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard-based self-checking bench for seq_divider (WIDTH=4)
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [3:0] dividend = '0, divisor = '0;
  logic in_ready, out_valid, div_by_zero;
  logic [3:0] quotient, remainder;
  logic [8:0] sb[$];
  logic [8:0] exp_v;
  int pass_cnt = 0;
  int total_cnt = 0;

  seq_divider #(.WIDTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] q, r;
    if (b == 4'd0) return {4'hF, a, 1'b1};
    q = a / b;
    r = a % b;
    return {q, r, 1'b0};
  endfunction

  task automatic send(input logic [3:0] a, input logic [3:0] b, input bit push);
    int n = 0;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) begin
      total_cnt++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (push) sb.push_back(model(a, b));
  endtask

  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 50; i++) begin
      if (out_valid) begin
        cyc = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== 11'b10_0000_0000_0)
      $display("FAIL reset_state: got %b required 10000000000",
               {in_ready, out_valid, quotient, remainder, div_by_zero});
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    out_ready = 1'b1;
    send(4'd13, 4'd3, 1'b1);
    total_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL basic_run_flags: in_ready=%0b out_valid=%0b required 0 0", in_ready, out_valid);
    else pass_cnt++;
    wait_valid(cyc);
    total_cnt++;
    if (cyc !== 5) $display("FAIL basic_latency: got %0d required 5", cyc);
    else pass_cnt++;
    exp_v = sb.pop_front();
    total_cnt++;
    if ({quotient, remainder, div_by_zero} !== exp_v)
      $display("FAIL basic_result: got %h/%h/%b required %h/%h/%b",
               quotient, remainder, div_by_zero, exp_v[8:5], exp_v[4:1], exp_v[0]);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL basic_ready_back: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_patterns();
    int cyc;
    logic [3:0] as[3] = '{4'd15, 4'd3, 4'd0};
    logic [3:0] bs[3] = '{4'd1, 4'd9, 4'd5};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(as[i], bs[i], 1'b1);
      wait_valid(cyc);
      total_cnt++;
      if (cyc !== 5) $display("FAIL pattern_latency[%0d]: got %0d required 5", i, cyc);
      else pass_cnt++;
      exp_v = sb.pop_front();
      total_cnt++;
      if ({quotient, remainder, div_by_zero} !== exp_v)
        $display("FAIL pattern_result[%0d]: got %h/%h/%b required %h/%h/%b", i,
                 quotient, remainder, div_by_zero, exp_v[8:5], exp_v[4:1], exp_v[0]);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    out_ready = 1'b1;
    send(4'd7, 4'd0, 1'b1);
    wait_valid(cyc);
    total_cnt++;
    if (cyc !== 1) $display("FAIL dbz_latency: got %0d required 1", cyc);
    else pass_cnt++;
    exp_v = sb.pop_front();
    total_cnt++;
    if ({quotient, remainder, div_by_zero} !== exp_v)
      $display("FAIL dbz_result: got %h/%h/%b required %h/%h/%b",
               quotient, remainder, div_by_zero, exp_v[8:5], exp_v[4:1], exp_v[0]);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL dbz_ready_back: got %0b required 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int cyc;
    out_ready = 1'b0;
    send(4'd14, 4'd4, 1'b1);
    wait_valid(cyc);
    total_cnt++;
    if (cyc !== 5) $display("FAIL stall_latency: got %0d required 5", cyc);
    else pass_cnt++;
    exp_v = sb.pop_front();
    dividend = 4'd1;
    divisor  = 4'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {2'b10, exp_v})
        $display("FAIL stall_hold[%0d]: got v=%0b r=%0b %h/%h/%b required v=1 r=0 %h/%h/%b", i,
                 out_valid, in_ready, quotient, remainder, div_by_zero,
                 exp_v[8:5], exp_v[4:1], exp_v[0]);
      else pass_cnt++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL stall_release: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL stall_no_ghost: out_valid=%0b required 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit ghost = 1'b0;
    out_ready = 1'b1;
    send(4'd13, 4'd3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== 11'b10_0000_0000_0)
      $display("FAIL midrun_reset_outputs: got %b required 10000000000",
               {in_ready, out_valid, quotient, remainder, div_by_zero});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL midrun_ready_after: got %0b required 1", in_ready);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) ghost = 1'b1;
      @(negedge clk);
    end
    total_cnt++;
    if (ghost !== 1'b0) $display("FAIL midrun_spurious_valid: got %0b required 0", ghost);
    else pass_cnt++;
    send(4'd9, 4'd2, 1'b1);
    wait_valid(cyc);
    exp_v = sb.pop_front();
    total_cnt++;
    if (cyc !== 5 || {quotient, remainder, div_by_zero} !== exp_v)
      $display("FAIL midrun_next: lat=%0d %h/%h/%b required lat=5 %h/%h/%b", cyc,
               quotient, remainder, div_by_zero, exp_v[8:5], exp_v[4:1], exp_v[0]);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_sweep();
    int cyc;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        out_ready = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(4'(a), 4'(b), 1'b1);
        wait_valid(cyc);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        exp_v = sb.pop_front();
        total_cnt++;
        if (cyc !== (b == 0 ? 1 : 5) || out_valid !== 1'b1 ||
            {quotient, remainder, div_by_zero} !== exp_v)
          $display("FAIL sweep %0d/%0d: lat=%0d v=%0b %h/%h/%b required lat=%0d v=1 %h/%h/%b",
                   a, b, cyc, out_valid, quotient, remainder, div_by_zero,
                   (b == 0 ? 1 : 5), exp_v[8:5], exp_v[4:1], exp_v[0]);
        else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clk);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_div_zero();
    test_stall();
    test_reset_mid_run();
    test_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
